// File: rtl/cmos_tft_pkg.sv
// Shared types and constants for the camera-to-TFT bridge.
// Optional colour-bar source is enabled with CMOS_TFT_TESTPAT_EN.
package cmos_tft_pkg;

    localparam int CNT_W = 11;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SKIP,
        ACTIVE,
        DONE
    } state_t;

    localparam logic [15:0] C_WHITE   = 16'hFFFF;
    localparam logic [15:0] C_YELLOW  = 16'hFFE0;
    localparam logic [15:0] C_CYAN    = 16'h07FF;
    localparam logic [15:0] C_GREEN   = 16'h07E0;
    localparam logic [15:0] C_MAGENTA = 16'hF81F;
    localparam logic [15:0] C_RED     = 16'hF800;
    localparam logic [15:0] C_BLUE    = 16'h001F;
    localparam logic [15:0] C_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/cmos_byte_pack.sv
// Packs the camera byte stream (high byte first) into RGB565 pixels.
// Odd trailing bytes are dropped because the phase clears with iLVAL.
module cmos_byte_pack (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iLVAL,
    input  logic [7:0]  iDATA,
    output logic [15:0] oPIX,
    output logic        oPIX_VALID
);

    logic       phase;
    logic [7:0] hi;

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            phase <= 1'b0;
            hi    <= 8'd0;
        end else if (!iLVAL) begin
            phase <= 1'b0;
        end else begin
            phase <= ~phase;
            if (!phase) hi <= iDATA;
        end
    end

    assign oPIX       = {hi, iDATA};
    assign oPIX_VALID = iLVAL & phase;

endmodule

// File: rtl/cmos_tft_bridge.sv
// OV76xx byte stream to 8080 TFT write bus with crop and frame skip.
// Define CMOS_TFT_TESTPAT_EN to add iTEST and a colour-bar source.
module cmos_tft_bridge
    import cmos_tft_pkg::*;
#(
    parameter int H_START    = 0,
    parameter int V_START    = 0,
    parameter int H_ACT      = 256,
    parameter int V_ACT      = 128,
    parameter int FRAME_SKIP = 0
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVSYNC,
    input  logic        iLVAL,
    input  logic [7:0]  iDATA,
    input  logic        iENABLE,
`ifdef CMOS_TFT_TESTPAT_EN
    input  logic        iTEST,
`endif
    output logic [15:0] oLCD_DATA,
    output logic        oLCD_WR,
    output logic        oLCD_CS,
    output logic        oLCD_RS,
    output logic        oLCD_RD,
    output logic        oLCD_RESET,
    output logic        oFRAME_DONE,
    output logic        oBUSY
);

    localparam int W1 = CNT_W + 1;
    localparam logic [W1-1:0] H_LO   = W1'(H_START);
    localparam logic [W1-1:0] H_HI   = W1'(H_START + H_ACT);
    localparam logic [W1-1:0] V_LO   = W1'(V_START);
    localparam logic [W1-1:0] V_HI   = W1'(V_START + V_ACT);
    localparam logic [W1-1:0] H_LAST = W1'(H_START + H_ACT - 1);
    localparam logic [W1-1:0] V_LAST = W1'(V_START + V_ACT - 1);
    localparam logic [CNT_W-1:0] SKIP_N = CNT_W'(FRAME_SKIP);

    state_t            state, nxt;
    logic              v_q, l_q;
    logic [CNT_W-1:0]  x, y, skip_cnt;
    logic              skip_pend, ok_q;
    logic [1:0]        last_sr;
    logic [15:0]       pix, pix_out;
    logic              pix_valid;
    logic              frame_start, v_rise, l_fall;
    logic              in_win, wr_en, is_last, fin;

    cmos_byte_pack u_pack (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iLVAL      (iLVAL),
        .iDATA      (iDATA),
        .oPIX       (pix),
        .oPIX_VALID (pix_valid)
    );

    assign frame_start = v_q & ~iVSYNC;
    assign v_rise      = ~v_q & iVSYNC;
    assign l_fall      = l_q & ~iLVAL;

    assign in_win = ({1'b0, x} >= H_LO) && ({1'b0, x} < H_HI) &&
                    ({1'b0, y} >= V_LO) && ({1'b0, y} < V_HI);
    assign wr_en   = (state == ACTIVE) && pix_valid && in_win;
    assign is_last = ({1'b0, x} == H_LAST) && ({1'b0, y} == V_LAST);
    // last_sr[1] lines up with the cycle the final WR rises
    assign fin     = last_sr[1] || ({1'b0, y} >= V_HI);

`ifdef CMOS_TFT_TESTPAT_EN
    logic [2:0] bar_idx;
    assign bar_idx = 3'(({3'b0, x - CNT_W'(H_START)} << 3) /
                        (CNT_W + 3)'(H_ACT));
    assign pix_out = iTEST ? bar_color(bar_idx) : pix;
`else
    assign pix_out = pix;
`endif

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE: if (frame_start && iENABLE)
                nxt = (skip_pend && FRAME_SKIP != 0) ? SKIP : ACTIVE;
            SKIP: if (frame_start) begin
                if (!iENABLE)              nxt = IDLE;
                else if (skip_cnt == SKIP_N) nxt = ACTIVE;
            end
            ACTIVE: begin
                if (frame_start)          nxt = iENABLE ? ACTIVE : IDLE;
                else if (fin || v_rise)   nxt = DONE;
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state     <= IDLE;
            v_q       <= 1'b0;
            l_q       <= 1'b0;
            x         <= '0;
            y         <= '0;
            skip_cnt  <= '0;
            skip_pend <= 1'b0;
            ok_q      <= 1'b0;
            last_sr   <= 2'b00;
            oLCD_DATA <= 16'd0;
            oLCD_WR   <= 1'b1;
        end else begin
            state   <= nxt;
            v_q     <= iVSYNC;
            l_q     <= iLVAL;
            ok_q    <= (state == ACTIVE) && fin;
            last_sr <= {last_sr[0], wr_en & is_last};
            oLCD_WR <= ~wr_en;
            if (wr_en) oLCD_DATA <= pix_out;

            if (!iLVAL)                         x <= '0;
            else if (pix_valid && x != CNT_MAX) x <= x + 1'b1;

            if (frame_start)                 y <= '0;
            else if (l_fall && y != CNT_MAX) y <= y + 1'b1;

            if (state == IDLE && nxt == SKIP)    skip_cnt <= CNT_W'(1);
            else if (state == SKIP && frame_start) skip_cnt <= skip_cnt + 1'b1;

            if (state == DONE && ok_q && FRAME_SKIP != 0) skip_pend <= 1'b1;
            else if (nxt == SKIP)                        skip_pend <= 1'b0;
        end
    end

    assign oFRAME_DONE = (state == DONE) && ok_q;
    assign oBUSY       = (state == SKIP) || (state == ACTIVE);
    assign oLCD_CS     = 1'b0;
    assign oLCD_RS     = 1'b1;
    assign oLCD_RD     = 1'b1;
    assign oLCD_RESET  = 1'b1;

endmodule
